// File: rtl/spad_bank_mem_if.sv
// Bus bundle for spad_bank_mem: write port, read-command port and read-data
// port, each with its own valid/ready handshake.
// The master side is the NoC unpacker plus the PE MAC datapath; the slave side
// is the scratchpad itself. Widths are derived the same way as in the scratchpad,
// so instantiate both with the same WIDTH/DEPTH/NUM_BANKS.
interface spad_bank_mem_if #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 5,
    parameter int NUM_BANKS = 2
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int LEN_W  = ADDR_W + 1;

    // Write port
    logic              wr_valid;
    logic              wr_ready;
    logic [BANK_W-1:0] wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    // Read-command port
    logic              rq_valid;
    logic              rq_ready;
    logic [BANK_W-1:0] rq_bank;
    logic [ADDR_W-1:0] rq_addr;
    logic              rq_stream;
    logic [LEN_W-1:0]  rq_len;

    // Read-data port
    logic              rd_valid;
    logic              rd_ready;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_last;

    // Sticky out-of-range indication
    logic              err;

    modport master (
        output wr_valid, wr_bank, wr_addr, wr_data,
        input  wr_ready,
        output rq_valid, rq_bank, rq_addr, rq_stream, rq_len,
        input  rq_ready,
        input  rd_valid, rd_data, rd_last,
        output rd_ready,
        input  err
    );

    modport slave (
        input  wr_valid, wr_bank, wr_addr, wr_data,
        output wr_ready,
        input  rq_valid, rq_bank, rq_addr, rq_stream, rq_len,
        output rq_ready,
        output rd_valid, rd_data, rd_last,
        input  rd_ready,
        output err
    );
endinterface

// File: rtl/spad_bank_mem.sv
// spad_bank_mem: multi-bank PE scratchpad (bank 0 = ifmap, bank 1 = filter, ...)
// with single reads and wrap-around streaming bursts feeding the MAC one word
// per cycle through a registered, back-pressurable output stage.
//
// Build option: define SPAD_FWD_EN to forward same-edge write data to a read
// of the same bank/address. Without it the read returns the previously stored
// value (read-before-write). The write commits in both builds.
module spad_bank_mem #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 5,
    parameter int NUM_BANKS = 2
) (
    input  logic clk,
    input  logic rst_n,
    spad_bank_mem_if.slave bus
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int LEN_W  = ADDR_W + 1;
    localparam int MEM_N  = NUM_BANKS * DEPTH;
    localparam int IDX_W  = (MEM_N > 1) ? $clog2(MEM_N) : 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    // ------------------------------------------------------------------
    // Address helpers
    // ------------------------------------------------------------------
    function automatic logic in_range(input logic [BANK_W-1:0] b,
                                      input logic [ADDR_W-1:0] a);
        return (int'(b) < NUM_BANKS) && (int'(a) < DEPTH);
    endfunction

    // Banks are laid out back to back in one flat array.
    function automatic logic [IDX_W-1:0] flat_idx(input logic [BANK_W-1:0] b,
                                                  input logic [ADDR_W-1:0] a);
        return IDX_W'(int'(b) * DEPTH + int'(a));
    endfunction

    // Streaming address step: the last valid entry wraps back to 0.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (int'(a) == DEPTH - 1) begin
            return '0;
        end
        return a + ADDR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  mem_q [MEM_N];
    logic              live_q;
    logic [0:0]        state_q,    state_d;
    logic [BANK_W-1:0] bank_q,     bank_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [LEN_W-1:0]  remain_q,   remain_d;
    logic              rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]  rd_data_q,  rd_data_d;
    logic              rd_last_q,  rd_last_d;
    logic              err_q,      err_d;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic              adv;
    logic              rq_ready;
    logic              rq_fire;
    logic              wr_fire;
    logic              wr_ok;
    logic [IDX_W-1:0]  wr_idx;

    // The output register may take a new word when empty or being drained.
    assign adv      = !rd_valid_q || bus.rd_ready;
    assign rq_ready = live_q && (state_q == S_IDLE) && adv;
    assign rq_fire  = bus.rq_valid && rq_ready;
    assign wr_fire  = bus.wr_valid && live_q;
    assign wr_ok    = in_range(bus.wr_bank, bus.wr_addr);
    assign wr_idx   = flat_idx(bus.wr_bank, bus.wr_addr);

    // ------------------------------------------------------------------
    // Read source: the incoming command while idle, the burst pointer while
    // streaming.
    // ------------------------------------------------------------------
    logic [BANK_W-1:0] src_bank;
    logic [ADDR_W-1:0] src_addr;
    logic              src_ok;
    logic [IDX_W-1:0]  src_idx;
    logic [WIDTH-1:0]  src_word;

    assign src_bank = (state_q == S_STREAM) ? bank_q : bus.rq_bank;
    assign src_addr = (state_q == S_STREAM) ? addr_q : bus.rq_addr;
    assign src_ok   = in_range(src_bank, src_addr);
    assign src_idx  = flat_idx(src_bank, src_addr);

    // Word to load into the output register; out-of-range beats read as zero.
    always_comb begin
        // NOTE: every always_comb output gets a default on entry so no path
        // leaves it unassigned, which would otherwise infer a latch.
        src_word = src_ok ? mem_q[src_idx] : '0;
`ifdef SPAD_FWD_EN
        if (src_ok && wr_fire && wr_ok &&
            (bus.wr_bank == src_bank) && (bus.wr_addr == src_addr)) begin
            src_word = bus.wr_data;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Next-state logic for the read FSM, output register and error flag.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_last_d  = rd_last_q;
        err_d      = err_q;

        if (wr_fire && !wr_ok) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (adv) begin
                    if (rq_fire) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = src_word;
                        if (!src_ok) begin
                            err_d = 1'b1;
                        end
                        if (bus.rq_stream && (bus.rq_len > LEN_W'(1))) begin
                            rd_last_d = 1'b0;
                            state_d   = S_STREAM;
                            bank_d    = bus.rq_bank;
                            addr_d    = next_addr(bus.rq_addr);
                            remain_d  = bus.rq_len - LEN_W'(1);
                        end else begin
                            rd_last_d = 1'b1;
                        end
                    end else begin
                        rd_valid_d = 1'b0;
                    end
                end
            end
            S_STREAM: begin
                if (adv) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = src_word;
                    if (!src_ok) begin
                        err_d = 1'b1;
                    end
                    addr_d   = next_addr(addr_q);
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        rd_last_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        rd_last_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register the read FSM, output stage and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bank_q     <= '0;
            addr_q     <= '0;
            remain_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
            err_q      <= err_d;
        end
    end

    // Flag that opens both input ports one edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // Bank storage: commits in-range writes; dropped writes only raise err.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the storage is register-based and cleared by reset because a
        // read of any entry after reset must return zero; this rules out
        // mapping it onto a RAM macro.
        if (!rst_n) begin
            for (int i = 0; i < MEM_N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_fire && wr_ok) begin
            mem_q[wr_idx] <= bus.wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.wr_ready = live_q;
    assign bus.rq_ready = rq_ready;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_last  = rd_last_q;
    assign bus.err      = err_q;

endmodule
